// File: rtl/fpu_wb_buffer.sv
// In-order result buffer between the FPU execute stage and write-back, with sticky fflags accumulation.
// Optional NaN-boxing of single-precision FP results on push: define FPU_WB_NANBOX_EN.
module fpu_wb_buffer #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ITAG_W = 6
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic                       flush_i,
  input  logic                       fpu_valid_i,
  output logic                       fpu_ready_o,
  input  logic [63:0]                fpu_result_i,
  input  logic [4:0]                 fpu_rd_i,
  input  logic                       fpu_frd_we_i,
  input  logic                       fpu_single_i,
  input  logic [4:0]                 fpu_fflags_i,
  input  logic [ITAG_W-1:0]          fpu_itag_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [63:0]                wb_result_o,
  output logic [4:0]                 wb_rd_o,
  output logic                       wb_frd_we_o,
  output logic [4:0]                 wb_fflags_o,
  output logic [ITAG_W-1:0]          wb_itag_o,
  input  logic                       fflags_clr_i,
  output logic [4:0]                 fflags_acc_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [63:0]       r_result_mem [DEPTH];
  logic [4:0]        r_rd_mem     [DEPTH];
  logic              r_frd_we_mem [DEPTH];
  logic [4:0]        r_fflags_mem [DEPTH];
  logic [ITAG_W-1:0] r_itag_mem   [DEPTH];

  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [4:0]        r_fflags_acc;

  logic              w_push;
  logic              w_pop;
  logic              w_not_full;
  logic              w_not_empty;
  logic [63:0]       w_push_result;

  // Ready depends only on registered occupancy and flush, never on wb_ready_i.
  assign w_not_full  = (r_count < FULL_CNT);
  assign w_not_empty = (r_count != '0);
  assign fpu_ready_o = w_not_full & ~flush_i;
  assign w_push      = fpu_valid_i & fpu_ready_o;
  assign w_pop       = w_not_empty & wb_ready_i & ~flush_i;

`ifdef FPU_WB_NANBOX_EN
  always_comb begin
    w_push_result = fpu_result_i;
    if (fpu_single_i && fpu_frd_we_i) begin
      w_push_result = {32'hFFFF_FFFF, fpu_result_i[31:0]};
    end
  end
`else
  logic w_unused_single;
  assign w_unused_single = fpu_single_i;
  assign w_push_result   = fpu_result_i;
`endif

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_result_mem[r_wptr] <= w_push_result;
      r_rd_mem[r_wptr]     <= fpu_rd_i;
      r_frd_we_mem[r_wptr] <= fpu_frd_we_i;
      r_fflags_mem[r_wptr] <= fpu_fflags_i;
      r_itag_mem[r_wptr]   <= fpu_itag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (arst_i || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // A clear discards the old value first, so a colliding pop leaves only its own flags.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      r_fflags_acc <= '0;
    end else if (fflags_clr_i) begin
      r_fflags_acc <= w_pop ? r_fflags_mem[r_rptr] : '0;
    end else if (w_pop) begin
      r_fflags_acc <= r_fflags_acc | r_fflags_mem[r_rptr];
    end
  end

  assign wb_valid_o   = w_not_empty;
  assign wb_result_o  = r_result_mem[r_rptr];
  assign wb_rd_o      = r_rd_mem[r_rptr];
  assign wb_frd_we_o  = r_frd_we_mem[r_rptr];
  assign wb_fflags_o  = r_fflags_mem[r_rptr];
  assign wb_itag_o    = r_itag_mem[r_rptr];
  assign fflags_acc_o = r_fflags_acc;
  assign count_o      = r_count;

endmodule
